// File: rtl/div_clock_monitor.sv
// Measures period and high time of a clk-synchronous divided clock, with lock and stall flags.
// Optional duty-cycle check is built only when DIVMON_DUTY_CHECK_EN is defined.
module div_clock_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_in,
    output logic [CNT_W:0]   period,
    output logic [CNT_W-1:0] high_len,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled,
    output logic             duty_err
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);

    state_t           state;
    logic             div_q;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [3:0]       match_cnt;

    logic             rise;
    logic [CNT_W:0]   new_period;
    logic             same_pair;
    logic [3:0]       next_match;

    assign rise       = div_in & ~div_q;
    assign new_period = {1'b0, high_cnt} + {1'b0, low_cnt};
    assign same_pair  = (new_period == period) && (high_cnt == high_len);

    // match_cnt == 0 marks the first period after IDLE, which never counts as a match
    always_comb begin
        next_match = 4'd1;
        if (match_cnt != 4'd0 && same_pair) begin
            if (match_cnt >= LOCK_N)
                next_match = LOCK_N;
            else
                next_match = match_cnt + 4'd1;
        end
    end

`ifdef DIVMON_DUTY_CHECK_EN
    logic [CNT_W-1:0] half_period;
    logic             duty_bad;

    assign half_period = new_period[CNT_W:1];
    assign duty_bad    = !((high_cnt == half_period) ||
                           (new_period[0] && (high_cnt == half_period + RUN_ONE)));
`else
    assign duty_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            div_q        <= 1'b0;
            high_cnt     <= '0;
            low_cnt      <= '0;
            match_cnt    <= 4'd0;
            period       <= '0;
            high_len     <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
`ifdef DIVMON_DUTY_CHECK_EN
            duty_err     <= 1'b0;
`endif
        end else begin
            div_q        <= div_in;
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    high_cnt <= '0;
                    low_cnt  <= '0;
                    if (rise) begin
                        high_cnt <= RUN_ONE;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (div_in) begin
                        if (high_cnt == RUN_LAST) begin
                            stalled   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= 4'd0;
                            high_cnt  <= '0;
                            low_cnt   <= '0;
                            state     <= IDLE;
`ifdef DIVMON_DUTY_CHECK_EN
                            duty_err  <= 1'b0;
`endif
                        end else begin
                            high_cnt <= high_cnt + RUN_ONE;
                        end
                    end else begin
                        low_cnt <= RUN_ONE;
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (!div_in) begin
                        if (low_cnt == RUN_LAST) begin
                            stalled   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= 4'd0;
                            high_cnt  <= '0;
                            low_cnt   <= '0;
                            state     <= IDLE;
`ifdef DIVMON_DUTY_CHECK_EN
                            duty_err  <= 1'b0;
`endif
                        end else begin
                            low_cnt <= low_cnt + RUN_ONE;
                        end
                    end else begin
                        period       <= new_period;
                        high_len     <= high_cnt;
                        period_valid <= 1'b1;
                        stalled      <= 1'b0;
                        match_cnt    <= next_match;
                        locked       <= (next_match >= LOCK_N);
                        high_cnt     <= RUN_ONE;
                        low_cnt      <= '0;
                        state        <= HIGH;
`ifdef DIVMON_DUTY_CHECK_EN
                        duty_err     <= duty_bad;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_clock_monitor.sv
// Self-checking bench for div_clock_monitor: directed divider patterns plus random run lengths,
// compared every cycle against a timestamp-based reference model.
module tb_div_clock_monitor;

    localparam int CNT_W      = 8;
    localparam int LOCK_COUNT = 3;
    localparam int RUN_LIMIT  = (1 << CNT_W) - 1;

    logic             clk;
    logic             resetn;
    logic             div_in;
    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] high_len;
    logic             period_valid;
    logic             locked;
    logic             stalled;
    logic             duty_err;

    int testCount;
    int failCount;

    // Reference model state: sample timestamps of the last rise and fall
    int  cyc;
    int  lastRise;
    int  lastFall;
    bit  prevS;
    int  histP[$];
    int  histH[$];
    int  expPeriod;
    int  expHigh;
    bit  expValid;
    bit  expLocked;
    bit  expStalled;
    bit  expDuty;

    div_clock_monitor #(
        .CNT_W(CNT_W),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .div_in(div_in),
        .period(period),
        .high_len(high_len),
        .period_valid(period_valid),
        .locked(locked),
        .stalled(stalled),
        .duty_err(duty_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function void modelReset();
        cyc = 0; lastRise = -1; lastFall = -1; prevS = 1'b0;
        histP.delete(); histH.delete();
        expPeriod = 0; expHigh = 0; expValid = 0;
        expLocked = 0; expStalled = 0; expDuty = 0;
    endfunction

    function void modelStall();
        expStalled = 1; expLocked = 0; expDuty = 0;
        histP.delete(); histH.delete();
        lastRise = -1; lastFall = -1;
    endfunction

    function void modelStep(bit s);
        int  p;
        int  h;
        int  n;
        bit  allSame;
        expValid = 0;
        if (lastRise < 0) begin
            if (s && !prevS) begin
                lastRise = cyc; lastFall = -1;
            end
        end else if (lastFall < 0) begin
            if (s) begin
                if (cyc - lastRise + 1 == RUN_LIMIT) modelStall();
            end else begin
                lastFall = cyc;
            end
        end else begin
            if (!s) begin
                if (cyc - lastFall + 1 == RUN_LIMIT) modelStall();
            end else begin
                p = cyc - lastRise;
                h = lastFall - lastRise;
                histP.push_back(p); histH.push_back(h);
                expPeriod = p; expHigh = h; expValid = 1; expStalled = 0;
                n = histP.size();
                allSame = (n >= LOCK_COUNT);
                if (allSame)
                    for (int i = 1; i < LOCK_COUNT; i++)
                        if (histP[n-1-i] != p || histH[n-1-i] != h) allSame = 0;
                expLocked = allSame;
`ifdef DIVMON_DUTY_CHECK_EN
                if (p % 2 == 0) expDuty = (h != p / 2);
                else            expDuty = !(h == (p - 1) / 2 || h == (p + 1) / 2);
`else
                expDuty = 0;
`endif
                lastRise = cyc; lastFall = -1;
            end
        end
        prevS = s;
        cyc++;
    endfunction

    task checkOutput();
        testCount++;
        assert (period === CNT_W'(0) + (CNT_W+1)'(expPeriod)) else begin
            failCount++; $error("FAIL period observed=%0d expected=%0d cyc=%0d", period, expPeriod, cyc);
        end
        testCount++;
        assert (high_len === CNT_W'(expHigh)) else begin
            failCount++; $error("FAIL high_len observed=%0d expected=%0d cyc=%0d", high_len, expHigh, cyc);
        end
        testCount++;
        assert (period_valid === expValid) else begin
            failCount++; $error("FAIL period_valid observed=%b expected=%b cyc=%0d", period_valid, expValid, cyc);
        end
        testCount++;
        assert (locked === expLocked) else begin
            failCount++; $error("FAIL locked observed=%b expected=%b cyc=%0d", locked, expLocked, cyc);
        end
        testCount++;
        assert (stalled === expStalled) else begin
            failCount++; $error("FAIL stalled observed=%b expected=%b cyc=%0d", stalled, expStalled, cyc);
        end
        testCount++;
        assert (duty_err === expDuty) else begin
            failCount++; $error("FAIL duty_err observed=%b expected=%b cyc=%0d", duty_err, expDuty, cyc);
        end
    endtask

    task applyStimulus(bit s);
        div_in = s;
        @(posedge clk);
        if (resetn) modelStep(s);
        else        modelReset();
        #1;
        checkOutput();
    endtask

    task applyPattern(int hi, int lo, int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) applyStimulus(1'b1);
            for (int i = 0; i < lo; i++) applyStimulus(1'b0);
        end
    endtask

    task checkConst(string tag, int observed, int expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++; $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        modelReset();
        div_in = 1'b0;
        resetn = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        resetn = 1'b1;

        // div2: lock after three matching periods
        applyPattern(1, 1, 6);
        checkConst("div2_period", int'(period), 2);
        checkConst("div2_locked", int'(locked), 1);

        // div6 with leading low phase
        applyStimulus(1'b0);
        for (int r = 0; r < 5; r++) begin
            applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b1);
            applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b0);
        end
        checkConst("div6_high", int'(high_len), 3);

        // div4 locked, then switch to div6
        applyPattern(2, 2, 5);
        checkConst("div4_locked", int'(locked), 1);
        applyPattern(3, 3, 5);

        // Stuck high, then resume div4
        applyPattern(2, 2, 5);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1);
        checkConst("stall_flag", int'(stalled), 1);
        checkConst("stall_period_hold", int'(period), 4);
        applyPattern(2, 2, 4);
        checkConst("stall_cleared", int'(stalled), 0);

        // Asynchronous reset in the middle of a high run
        applyStimulus(1'b1);
        #1 resetn = 1'b0;
        #1;
        modelReset();
        checkConst("async_rst_period", int'(period), 0);
        checkConst("async_rst_locked", int'(locked), 0);
        checkConst("async_rst_valid", int'(period_valid), 0);
        @(negedge clk);
        resetn = 1'b1;
        applyPattern(2, 2, 5);

        // Duty patterns: 1/3 then 2/2
        applyPattern(1, 3, 4);
        applyPattern(2, 2, 4);

        // Stuck low from a low run
        applyStimulus(1'b1);
        for (int i = 0; i < 260; i++) applyStimulus(1'b0);
        applyPattern(3, 2, 3);

        // Randomized run lengths with occasional stuck input
        for (int b = 0; b < 40; b++) begin
            if (b % 13 == 12) begin
                automatic bit v = 1'($urandom_range(0, 1));
                automatic int len = $urandom_range(250, 262);
                for (int i = 0; i < len; i++) applyStimulus(v);
            end else begin
                applyPattern($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 5));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
